// File: rtl/cpu_pkg.sv
// Shared definitions for the simple RISC CPU: opcode map, controller state
// encoding, phase width and the packed control-strobe vector.
package cpu_pkg;

    localparam int OPW = 3;
    localparam int PHW = 3;

    localparam logic [PHW-1:0] PH_HALT = 3'd3;
    localparam logic [PHW-1:0] PH_LAST = 3'd7;

    typedef enum logic [OPW-1:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    // Bit order fixes the layout of the 8-bit strobe vector (inc_pc is bit 0).
    typedef struct packed {
        logic halt;
        logic datactl_ena;
        logic load_pc;
        logic load_acc;
        logic wr;
        logic rd;
        logic load_ir;
        logic inc_pc;
    } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-phase decoder: (phase, opcode, zero) to the
// control-strobe vector registered by machine_ctrl.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [PHW-1:0] phase_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           zero_i,
    output strobes_t       strobes_o
);

    logic is_alu;

    assign is_alu = (opcode_i == ADD) || (opcode_i == AND) ||
                    (opcode_i == XOR) || (opcode_i == LDA);

    always_comb begin
        strobes_o = '0;
        case (phase_i)
            3'd0, 3'd1: begin
                strobes_o.rd      = 1'b1;
                strobes_o.load_ir = 1'b1;
                strobes_o.inc_pc  = 1'b1;
            end
            3'd3: strobes_o.halt = (opcode_i == HLT);
            3'd4: begin
                strobes_o.rd          = is_alu;
                strobes_o.load_pc     = (opcode_i == JMP);
                strobes_o.datactl_ena = (opcode_i == STO);
            end
            3'd5: begin
                strobes_o.rd          = is_alu;
                strobes_o.load_acc    = is_alu;
                strobes_o.load_pc     = (opcode_i == JMP);
                strobes_o.inc_pc      = (opcode_i == JMP);
                strobes_o.wr          = (opcode_i == STO);
                strobes_o.datactl_ena = (opcode_i == STO);
            end
            3'd6: strobes_o.datactl_ena = (opcode_i == STO);
            3'd7: strobes_o.inc_pc = (opcode_i == SKZ) && zero_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/machine_ctrl.sv
// Instruction-cycle controller: 8-phase sequencer started by fetch, registered
// control strobes, sticky halt. Define FETCH_RESYNC_EN to realign on fetch rise.
module machine_ctrl
    import cpu_pkg::*;
#(
    parameter int OPW = cpu_pkg::OPW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fetch,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           inc_pc,
    output logic           load_ir,
    output logic           rd,
    output logic           wr,
    output logic           load_acc,
    output logic           load_pc,
    output logic           datactl_ena,
    output logic           halt
);

    state_e          state_q, state_d;
    logic [PHW-1:0]  phase_q, phase_d;
    strobes_t        out_q, out_d;
    strobes_t        dec;

    ctrl_decode u_decode (
        .phase_i   (phase_q),
        .opcode_i  (opcode),
        .zero_i    (zero),
        .strobes_o (dec)
    );

`ifdef FETCH_RESYNC_EN
    logic fetch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= 1'b0;
        end else begin
            fetch_q <= fetch;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        out_d   = '0;
        case (state_q)
            IDLE: begin
                if (fetch) begin
                    state_d = RUN;
                    phase_d = '0;
                end
            end
            RUN: begin
                out_d   = dec;
                phase_d = phase_q + PHW'(1);
                if ((phase_q == PH_HALT) && (opcode == HLT)) begin
                    state_d = HALTED;
                end
`ifdef FETCH_RESYNC_EN
                // A fetch rise away from phase 7 aborts the misaligned cycle,
                // including a pending halt.
                if (fetch && !fetch_q) begin
                    phase_d = '0;
                    if (phase_q != PH_LAST) begin
                        out_d   = '0;
                        state_d = RUN;
                    end
                end
`endif
            end
            HALTED: out_d.halt = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

    assign inc_pc      = out_q.inc_pc;
    assign load_ir     = out_q.load_ir;
    assign rd          = out_q.rd;
    assign wr          = out_q.wr;
    assign load_acc    = out_q.load_acc;
    assign load_pc     = out_q.load_pc;
    assign datactl_ena = out_q.datactl_ena;
    assign halt        = out_q.halt;

endmodule

// File: tb/tb_machine_ctrl.sv
// Self-checking bench for machine_ctrl: vector table, directed corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_machine_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch = 1'b0;
    logic       zero = 1'b0;
    logic [2:0] opcode = 3'd0;
    wire        inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt;

    always #5 clk = ~clk;

    machine_ctrl #(.OPW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .opcode      (opcode),
        .zero        (zero),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    localparam logic [2:0] O_HLT = 3'd0, O_SKZ = 3'd1, O_ADD = 3'd2, O_AND = 3'd3,
                           O_XOR = 3'd4, O_LDA = 3'd5, O_STO = 3'd6, O_JMP = 3'd7;
    localparam logic [7:0] B_INC = 8'h01, B_IR = 8'h02, B_RD = 8'h04, B_WR = 8'h08,
                           B_ACC = 8'h10, B_PC = 8'h20, B_DAT = 8'h40, B_HLT = 8'h80;
    localparam logic [7:0] RII = B_RD | B_IR | B_INC;

    wire [7:0] dv = {halt, datactl_ena, load_pc, load_acc, wr, rd, load_ir, inc_pc};

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: running flag, clocks since cycle start, sticky halt.
    bit         m_run = 1'b0;
    bit         m_halt = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_exp = 8'h00;
`ifdef FETCH_RESYNC_EN
    bit         m_prevf = 1'b0;
`endif

    typedef struct {
        bit         f;
        logic [2:0] op;
        bit         z;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [7:0] rule(int p, logic [2:0] op, bit z);
        bit alu;
        alu = (op == O_ADD) || (op == O_AND) || (op == O_XOR) || (op == O_LDA);
        if (p == 0 || p == 1) return RII;
        if (p == 3) return (op == O_HLT) ? B_HLT : 8'h00;
        if (p == 4) return alu ? B_RD : (op == O_JMP) ? B_PC : (op == O_STO) ? B_DAT : 8'h00;
        if (p == 5) return alu ? (B_RD | B_ACC) : (op == O_JMP) ? (B_PC | B_INC) :
                           (op == O_STO) ? (B_WR | B_DAT) : 8'h00;
        if (p == 6) return (op == O_STO) ? B_DAT : 8'h00;
        if (p == 7) return (op == O_SKZ && z) ? B_INC : 8'h00;
        return 8'h00;
    endfunction

    task automatic model_edge(bit f, logic [2:0] op, bit z);
        int p;
`ifdef FETCH_RESYNC_EN
        bit rise;
        rise = f && !m_prevf;
        m_prevf = f;
`endif
        if (m_halt) begin
            m_exp = B_HLT;
        end else if (!m_run) begin
            m_exp = 8'h00;
            if (f) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            p = m_pos;
            m_pos = (m_pos + 1) % 8;
            m_exp = rule(p, op, z);
            if (p == 3 && op == O_HLT) m_halt = 1'b1;
`ifdef FETCH_RESYNC_EN
            if (rise) begin
                m_pos = 0;
                if (p != 7) begin
                    m_exp = 8'h00;
                    m_halt = 1'b0;
                end
            end
`endif
        end
    endtask

    task automatic check_m(string name, logic [7:0] mask, logic [7:0] exp);
        total++;
        if ((dv & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got=%h want=%h mask=%h t=%0t", name, dv, exp, mask, $time);
        end
    endtask

    task automatic check(string name, logic [7:0] exp);
        check_m(name, 8'hff, exp);
    endtask

    // Drive inputs, clock once, then compare against the model.
    task automatic tick(bit f, logic [2:0] op, bit z);
        fetch = f;
        opcode = op;
        zero = z;
        @(posedge clk);
        #1;
        model_edge(f, op, z);
        check("model", m_exp);
    endtask

    task automatic cyc_tick(logic [2:0] op, bit z);
        tick((cyc % 8) < 4, op, z);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fetch = 1'b0;
        #1;
        check("reset_async", 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b0;
        m_run = 1'b0;
        m_halt = 1'b0;
        m_pos = 0;
        m_exp = 8'h00;
`ifdef FETCH_RESYNC_EN
        m_prevf = 1'b0;
`endif
        cyc = 0;
    endtask

    initial begin
        tbl[0] = '{1'b1, O_LDA, 1'b0, 8'h00};
        tbl[1] = '{1'b1, O_LDA, 1'b1, RII};
        tbl[2] = '{1'b1, O_LDA, 1'b0, RII};
        tbl[3] = '{1'b1, O_LDA, 1'b1, 8'h00};
        tbl[4] = '{1'b0, O_LDA, 1'b0, 8'h00};
        tbl[5] = '{1'b0, O_LDA, 1'b1, B_RD};
        tbl[6] = '{1'b0, O_LDA, 1'b0, B_RD | B_ACC};
        tbl[7] = '{1'b0, O_LDA, 1'b1, 8'h00};
        tbl[8] = '{1'b1, O_LDA, 1'b0, 8'h00};

        // LDA first instruction from the vector table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].f, tbl[i].op, tbl[i].z);
            check("lda_tbl", tbl[i].exp);
        end

        // STO: datactl at E+5..E+7, wr only at E+6, no rd after E+2
        do_reset();
        for (int k = 0; k < 9; k++) begin
            cyc_tick(O_STO, 1'b0);
            check_m("sto_dat", B_DAT, (k >= 5 && k <= 7) ? B_DAT : 8'h00);
            check_m("sto_wr", B_WR, (k == 6) ? B_WR : 8'h00);
            if (k > 2) check_m("sto_nord", B_RD, 8'h00);
        end

        // SKZ: zero=1 for the first instruction, zero=0 for the second
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cyc_tick(O_SKZ, k < 9);
            if (k == 8)  check("skz_z1", B_INC);
            if (k == 16) check("skz_z0", 8'h00);
        end

        // HLT: sticky halt with fetch still toggling, cleared by async reset
        do_reset();
        for (int k = 0; k < 55; k++) begin
            cyc_tick((k < 5) ? O_HLT : 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (k >= 4) check("hlt_hold", B_HLT);
        end
        #2;
        do_reset();

        // JMP over three fetch periods
        do_reset();
        for (int k = 0; k < 25; k++) begin
            cyc_tick(O_JMP, 1'b1);
            check_m("jmp_pc", B_PC, ((k % 8) == 5 || (k % 8) == 6) && k > 0 ? B_PC : 8'h00);
            if (k == 9 || k == 17) check("jmp_realign", RII);
        end

        // Early fetch rise while phase==3
        do_reset();
        tick(1'b1, O_ADD, 1'b0);
        tick(1'b0, O_ADD, 1'b0);
        tick(1'b0, O_ADD, 1'b0);
        tick(1'b0, O_ADD, 1'b0);
        tick(1'b1, O_ADD, 1'b0);
        check("early_rise", 8'h00);
        tick(1'b1, O_ADD, 1'b0);
`ifdef FETCH_RESYNC_EN
        check("resync_next", RII);
`else
        check("resync_next", B_RD);
`endif
        cyc = 2;
        for (int k = 0; k < 12; k++) cyc_tick(O_ADD, 1'b0);

        // Randomized traffic with occasional fetch glitches and resets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [2:0] op;
            bit         z;
            bit         f;
            op = ($urandom_range(0, 31) == 0) ? O_HLT : 3'($urandom_range(1, 7));
            z = 1'($urandom_range(0, 1));
            f = (cyc % 8) < 4;
            if ($urandom_range(0, 15) == 0) f = ~f;
            tick(f, op, z);
            cyc++;
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
